// File: rtl/sdram_cmd_phy.sv
// SDRAM command/address pin driver: runs the power-up init sequence after reset,
// then forwards scheduler commands to the pins with one cycle of latency.
module sdram_cmd_phy #(
   parameter int W_RADDR        = 13,
   parameter int W_BANKSEL      = 2,
   parameter int W_INIT_CTR     = 16,
   parameter int W_TIME_CTR     = 3,
   parameter int N_INIT_REFRESH = 2,
   parameter int BURST_LEN      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [W_INIT_CTR-1:0] cfg_init_wait,
   input  logic [W_TIME_CTR-1:0] time_rp,
   input  logic [W_TIME_CTR-1:0] time_rc,
   input  logic [W_TIME_CTR-1:0] time_mrd,
   input  logic [1:0]            time_cas,
   input  logic                  cmd_vld,
   input  logic                  cmd_ras_n,
   input  logic                  cmd_cas_n,
   input  logic                  cmd_we_n,
   input  logic [W_RADDR-1:0]    cmd_addr,
   input  logic [W_BANKSEL-1:0]  cmd_banksel,
   output logic                  init_done,
   output logic                  cmd_dropped,
   output logic                  sdram_cke,
   output logic                  sdram_cs_n,
   output logic                  sdram_ras_n,
   output logic                  sdram_cas_n,
   output logic                  sdram_we_n,
   output logic [W_RADDR-1:0]    sdram_addr,
   output logic [W_BANKSEL-1:0]  sdram_ba
);

   localparam int                  W_REF     = $clog2(N_INIT_REFRESH + 1);
   localparam logic [W_REF-1:0]    REF_LAST  = W_REF'(N_INIT_REFRESH);
   localparam logic [2:0]          BL_CODE   = 3'($clog2(BURST_LEN));
   localparam logic [W_RADDR-1:0]  ADDR_PALL = W_RADDR'(1) << 10;

   localparam logic [2:0] C_NOP = 3'b111;
   localparam logic [2:0] C_PRE = 3'b010;
   localparam logic [2:0] C_REF = 3'b001;
   localparam logic [2:0] C_LMR = 3'b000;

   // Each state names what is on the pins during that cycle; S_RESET exists only under reset.
   typedef enum logic [3:0] {
      S_RESET, S_POWERUP, S_PRECHARGE, S_WAIT_RP, S_REFRESH,
      S_WAIT_RC, S_LOAD_MODE, S_WAIT_MRD, S_DONE
   } state_t;

   state_t                state, state_nxt, ref_exit;
   logic [W_INIT_CTR-1:0] cnt, cnt_nxt;
   logic [W_REF-1:0]      ref_cnt, ref_cnt_nxt;
   logic [2:0]            pin_cmd_nxt;
   logic [W_RADDR-1:0]    addr_nxt;
   logic [W_BANKSEL-1:0]  ba_nxt;
   logic                  dropped_nxt;

   // A wait of T NOP cycles is counted T-1 down to 0; T = 0 skips the wait state.
   function automatic logic [W_INIT_CTR-1:0] wait_load(input logic [W_TIME_CTR-1:0] t);
      return W_INIT_CTR'(t) - W_INIT_CTR'(1);
   endfunction

   // cmd_vld qualifies cmd_* for a single cycle with no ready: the scheduler may only
   // present commands while init_done = 1; anything earlier is discarded and flagged.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      ref_cnt_nxt = ref_cnt;
      pin_cmd_nxt = C_NOP;
      addr_nxt    = sdram_addr;
      ba_nxt      = sdram_ba;
      dropped_nxt = cmd_dropped | (cmd_vld & ~init_done);
      ref_exit    = (ref_cnt == REF_LAST) ? S_LOAD_MODE : S_REFRESH;

      case (state)
         S_RESET: begin
            state_nxt = S_POWERUP;
            cnt_nxt   = cfg_init_wait;
         end
         S_POWERUP: begin
            if (cnt == '0) state_nxt = S_PRECHARGE;
            else           cnt_nxt   = cnt - W_INIT_CTR'(1);
         end
         S_PRECHARGE: begin
            if (time_rp == '0) begin
               state_nxt = S_REFRESH;
            end else begin
               state_nxt = S_WAIT_RP;
               cnt_nxt   = wait_load(time_rp);
            end
         end
         S_WAIT_RP: begin
            if (cnt == '0) state_nxt = S_REFRESH;
            else           cnt_nxt   = cnt - W_INIT_CTR'(1);
         end
         S_REFRESH: begin
            if (time_rc == '0) begin
               state_nxt = ref_exit;
            end else begin
               state_nxt = S_WAIT_RC;
               cnt_nxt   = wait_load(time_rc);
            end
         end
         S_WAIT_RC: begin
            if (cnt == '0) state_nxt = ref_exit;
            else           cnt_nxt   = cnt - W_INIT_CTR'(1);
         end
         S_LOAD_MODE: begin
            if (time_mrd == '0) begin
               state_nxt = S_DONE;
            end else begin
               state_nxt = S_WAIT_MRD;
               cnt_nxt   = wait_load(time_mrd);
            end
         end
         S_WAIT_MRD: begin
            if (cnt == '0) state_nxt = S_DONE;
            else           cnt_nxt   = cnt - W_INIT_CTR'(1);
         end
         S_DONE:  state_nxt = S_DONE;
         default: state_nxt = S_RESET;
      endcase

      // Pins are registered from the state being entered, so they line up with it.
      case (state_nxt)
         S_PRECHARGE: begin
            pin_cmd_nxt = C_PRE;
            addr_nxt    = ADDR_PALL;
            ba_nxt      = '0;
         end
         S_REFRESH: begin
            pin_cmd_nxt = C_REF;
            ref_cnt_nxt = ref_cnt + W_REF'(1);
         end
         S_LOAD_MODE: begin
            pin_cmd_nxt = C_LMR;
            addr_nxt    = W_RADDR'({1'b0, time_cas, 1'b0, BL_CODE});
            ba_nxt      = '0;
         end
         default: ;
      endcase

      if (init_done && cmd_vld) begin
         pin_cmd_nxt = {cmd_ras_n, cmd_cas_n, cmd_we_n};
         addr_nxt    = cmd_addr;
         ba_nxt      = cmd_banksel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_RESET;
         cnt         <= '0;
         ref_cnt     <= '0;
         sdram_cke   <= 1'b0;
         sdram_cs_n  <= 1'b1;
         sdram_ras_n <= 1'b1;
         sdram_cas_n <= 1'b1;
         sdram_we_n  <= 1'b1;
         sdram_addr  <= '0;
         sdram_ba    <= '0;
         init_done   <= 1'b0;
         cmd_dropped <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         ref_cnt     <= ref_cnt_nxt;
         sdram_cke   <= 1'b1;
         sdram_cs_n  <= 1'b0;
         {sdram_ras_n, sdram_cas_n, sdram_we_n} <= pin_cmd_nxt;
         sdram_addr  <= addr_nxt;
         sdram_ba    <= ba_nxt;
         init_done   <= (state_nxt == S_DONE);
         cmd_dropped <= dropped_nxt;
      end
   end

endmodule

// File: doc/sdram_cmd_phy.md
Name: sdram_cmd_phy

Overview:
- Sits directly downstream of the SDRAM scheduler and drives the SDRAM command/address pins.
- After reset it runs the JEDEC power-up sequence itself: NOP wait, PRECHARGE ALL, N × AUTO REFRESH, LOAD MODE REGISTER.
- It then asserts init_done and forwards scheduler commands to the pins through one register stage.
- Cycles with no scheduler command are driven as NOP.

Parameters:
- W_RADDR, 13, row/command address width (A10 = precharge-all bit).
- W_BANKSEL, 2, bank select width.
- W_INIT_CTR, 16, power-up wait counter width.
- W_TIME_CTR, 3, width of timing inputs.
- N_INIT_REFRESH, 2, AUTO REFRESH commands issued during init (≥1).
- BURST_LEN, 8, burst length encoded into mode register; legal values 1, 2, 4, 8.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_init_wait  in  W_INIT_CTR  power-up NOP cycles minus 1
- time_rp  in  W_TIME_CTR  tRP, cycles minus 1
- time_rc  in  W_TIME_CTR  tRC (refresh-to-command), cycles minus 1
- time_mrd  in  W_TIME_CTR  tMRD, cycles minus 1
- time_cas  in  2  CAS latency, written to mode register
- cmd_vld  in  1  scheduler command valid
- cmd_ras_n / cmd_cas_n / cmd_we_n  in  1 each  scheduler command
- cmd_addr  in  W_RADDR  scheduler address
- cmd_banksel  in  W_BANKSEL  scheduler bank
- init_done  out  1  init complete; top level gates scheduler req_vld with it
- cmd_dropped  out  1  sticky: cmd_vld seen while init_done = 0
- sdram_cke  out  1  clock enable
- sdram_cs_n / sdram_ras_n / sdram_cas_n / sdram_we_n  out  1 each  command pins
- sdram_addr  out  W_RADDR  address pins
- sdram_ba  out  W_BANKSEL  bank pins

Behaviour:
- All pin outputs are registered.
- Reset values:
  - sdram_cke = 0
  - sdram_cs_n = sdram_ras_n = sdram_cas_n = sdram_we_n = 1 (deselect)
  - sdram_addr = 0, sdram_ba = 0
  - init_done = 0, cmd_dropped = 0
- Asserting rst_n low mid-operation (including after DONE) immediately returns all outputs to reset values; the full sequence reruns on release.
- Command encoding {ras_n, cas_n, we_n}, with cs_n = 0 for all:
  - NOP 111, PRECHARGE 010, REFRESH 001, LOAD_MODE 000.
- Timing convention: a command on pins in cycle t with timing value T allows the next command on pins no earlier than cycle t+T+1. All intervening cycles are NOP.
- Cycle 1 is the first posedge after reset release.
- FSM states:
  - POWERUP (entered from reset):
    - sdram_cke = 1, cs_n = 0, NOP.
    - Down-counter loaded with cfg_init_wait on entry; NOP is driven for cfg_init_wait+1 cycles.
    - cfg_init_wait = 0 gives one NOP cycle.
    - At the counter's maximum value the count is not truncated.
  - PRECHARGE: one cycle PRECHARGE, sdram_addr[10] = 1, all other addr bits 0, ba = 0. Then WAIT_RP (time_rp NOP cycles).
  - REFRESH:
    - One cycle REFRESH, then WAIT_RC (time_rc NOPs).
    - A refresh counter (width $clog2(N_INIT_REFRESH+1)) increments per REFRESH.
    - Go back to REFRESH until N_INIT_REFRESH have been issued, then go to LOAD_MODE.
  - LOAD_MODE:
    - One cycle LOAD_MODE; ba = 0.
    - addr[2:0] = BL code: 1→000, 2→001, 4→010, 8→011.
    - addr[3] = 0 (sequential).
    - addr[6:4] = {1'b0, time_cas}.
    - All higher address bits 0 (burst write enabled).
    - Then WAIT_MRD (time_mrd NOPs).
  - DONE:
    - init_done = 1 from the first cycle in which the tMRD constraint is satisfied. It stays 1 until reset.
    - Each cycle, inputs are sampled and driven to pins the next cycle (latency 1):
      - cmd_vld = 1 → cs_n = 0, ras/cas/we from cmd_*, addr = cmd_addr, ba = cmd_banksel.
      - cmd_vld = 0 → NOP; addr/ba hold their previous values.
    - cke stays 1.
- Timing inputs are sampled when each wait is entered; changes mid-wait do not affect the current wait.
- While init_done = 0, cmd_* inputs are ignored. If cmd_vld = 1 in any such cycle, cmd_dropped sets next cycle and stays set until reset.
- The FSM never returns to init states without reset.

Test Plan:
- Reset release with cfg_init_wait=3, time_rp=1, time_rc=2, time_mrd=1, time_cas=2, BURST_LEN=8 → expected pin sequence:
  - cke=1 from cycle 1; NOP cycles 1–4.
  - PRECHARGE cycle 5 with addr[10]=1.
  - REFRESH cycles 7 and 10.
  - LOAD_MODE cycle 13 with addr=0x023.
  - init_done=1 from cycle 15.
  - NOP in all other cycles.
- After init, cmd_vld=1, cmd=011 (ACTIVATE), addr=0x1ABC, ba=2 in cycle N → pins show cs_n=0, 011, 0x1ABC, ba=2 in cycle N+1; cycle N+2 shows NOP if cmd_vld=0.
- cmd_vld pulsed in cycle 6 (during init) → pins unaffected; cmd_dropped=1 from cycle 7 onward; init timing identical to scenario 1.
- N_INIT_REFRESH=4, time_rc=0, cfg_init_wait=0 → PRECHARGE cycle 2; REFRESH cycles 4, 5, 6, 7; LOAD_MODE cycle 8.
- Reset asserted in cycle 8 (mid-refresh), released, then scenario 1 stimulus → outputs at reset values during reset; full sequence restarts from cycle 1.
- BURST_LEN=4, time_cas=3 → LOAD_MODE addr=0x032.
